qsys_multi_timer: RTL



---
 rtl/qsys_multi_timer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/qsys_multi_timer.sv
// qsys_multi_timer: NUM_CH independent CNT_W-bit down-counters behind one 16-bit Avalon-MM slave.
// Define QSYS_MULTI_TIMER_PRESCALE_EN to add a shared tick prescaler (parameter PRESCALE_DIV).
module qsys_multi_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 49999
`ifdef QSYS_MULTI_TIMER_PRESCALE_EN
  ,
  parameter int PRESCALE_DIV = 50
`endif
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [3+$clog2(NUM_CH)-1:0] address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [15:0]                 writedata,
  output logic [15:0]                 readdata,
  output logic                        irq,
  output logic [NUM_CH-1:0]           irq_vec
);

  localparam logic [CNT_W-1:0] RST_P = CNT_W'(RESET_PERIOD);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0]  r_period [NUM_CH];
  logic [CNT_W-1:0]  r_cnt    [NUM_CH];
  logic [CNT_W-1:0]  r_snap   [NUM_CH];
  logic [3:0]        r_ctrl   [NUM_CH];
  logic [NUM_CH-1:0] r_to;
  logic [NUM_CH-1:0] r_run;
  logic [NUM_CH-1:0] r_force;
  logic [NUM_CH-1:0] r_zero_d;
  logic [15:0]       r_rd;

  logic              w_wr;
  logic [2:0]        w_reg;
  logic [31:0]       w_ch;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_zero;
  logic [NUM_CH-1:0] w_event;
  logic [NUM_CH-1:0] w_ito;
  logic              w_tick;
  logic [15:0]       w_rd;

  assign w_wr  = chipselect & ~write_n;
  assign w_reg = address[2:0];
  assign w_ch  = 32'(address) >> 3;

  always_comb begin
    w_sel   = '0;
    w_zero  = '0;
    w_event = '0;
    w_ito   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sel[i]   = w_wr && (w_ch == 32'(i));
      w_zero[i]  = (r_cnt[i] == '0);
      w_event[i] = w_zero[i] & ~r_zero_d[i];
      w_ito[i]   = r_ctrl[i][0];
    end
  end

`ifdef QSYS_MULTI_TIMER_PRESCALE_EN
  logic [31:0] r_pre;
  logic        w_per_wr_any;

  // Any period write realigns the shared tick so the new period starts on a full prescale interval.
  assign w_per_wr_any = (|w_sel) && (w_reg == 3'd2 || w_reg == 3'd3);
  assign w_tick       = (r_pre == 32'(PRESCALE_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     r_pre <= '0;
    else if (w_per_wr_any || w_tick)  r_pre <= '0;
    else                              r_pre <= r_pre + 32'd1;
  end
`else
  assign w_tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_period[i] <= RST_P;
        r_cnt[i]    <= RST_P;
        r_snap[i]   <= '0;
        r_ctrl[i]   <= '0;
      end
      r_to     <= '0;
      r_run    <= '0;
      r_force  <= '0;
      r_zero_d <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_zero_d[i] <= w_zero[i];
        r_force[i]  <= w_sel[i] && (w_reg == 3'd2 || w_reg == 3'd3);
        if (w_sel[i] && w_reg == 3'd1) r_ctrl[i] <= writedata[3:0];
        if (w_sel[i] && w_reg == 3'd2) r_period[i][15:0] <= writedata;
        if (w_sel[i] && w_reg == 3'd3) r_period[i][CNT_W-1:16] <= writedata[CNT_W-17:0];
        if (w_sel[i] && (w_reg == 3'd4 || w_reg == 3'd5)) r_snap[i] <= r_cnt[i];
        // Timeout set beats a same-cycle status clear so no event is lost.
        if (w_event[i])                     r_to[i] <= 1'b1;
        else if (w_sel[i] && w_reg == 3'd0) r_to[i] <= 1'b0;
        if (r_force[i]) begin
          r_cnt[i] <= r_period[i];
        end else if (r_run[i] && w_tick) begin
          if (!w_zero[i])        r_cnt[i] <= r_cnt[i] - ONE;
          else if (r_ctrl[i][1]) r_cnt[i] <= r_period[i];
        end
        if (w_sel[i] && w_reg == 3'd1 && writedata[2])
          r_run[i] <= 1'b1;
        else if ((w_sel[i] && w_reg == 3'd1 && writedata[3]) || r_force[i] ||
                 (r_run[i] && w_tick && w_zero[i] && !r_ctrl[i][1]))
          r_run[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == 32'(i)) begin
        case (w_reg)
          3'd0:    w_rd = {14'd0, r_run[i], r_to[i]};
          3'd1:    w_rd = {12'd0, r_ctrl[i]};
          3'd2:    w_rd = r_period[i][15:0];
          3'd3:    w_rd = 16'(r_period[i] >> 16);
          3'd4:    w_rd = r_snap[i][15:0];
          3'd5:    w_rd = 16'(r_snap[i] >> 16);
          3'd6:    w_rd = 16'(r_to);
          default: w_rd = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rd <= '0;
    else          r_rd <= w_rd;
  end

  assign readdata = r_rd;
  assign irq_vec  = r_to & w_ito;
  assign irq      = |irq_vec;

endmodule
